// File: rtl/if_id_buffer.sv
// Fetch-to-decode buffer: small in-order FIFO of {Instruction, PC} pairs with a
// valid/ready head, fetch back-pressure, flush, and a saturating discard counter.
module if_id_buffer #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instruction,
  input  logic [31:0]       PCResult,
  input  logic              InValid,
  output logic              InReady,
  input  logic              Flush,
  output logic [31:0]       ID_Instruction,
  output logic [31:0]       ID_PC,
  output logic [31:0]       ID_PCPlus4,
  output logic              ID_Valid,
  input  logic              ID_Ready,
  output logic [PTR_W:0]    Count,
  output logic [7:0]        DiscardCount
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem_instr [DEPTH];
  logic [31:0]      r_mem_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_discard;

  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [PTR_W:0]   w_count_next;
  logic [7:0]       w_discard_next;
  logic [15:0]      w_discard_sum;
  logic             w_push;
  logic             w_pop;
  logic             w_write_en;
  logic [31:0]      w_head_instr;
  logic [31:0]      w_head_pc;

  assign InReady  = (r_count != FULL_COUNT);
  assign ID_Valid = (r_count != '0);
  assign w_push   = InValid & InReady;
  assign w_pop    = ID_Valid & ID_Ready;
  // A flushed push never lands in storage; reset likewise suppresses writes.
  assign w_write_en = Reset & w_push & ~Flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge Clk) begin
        if (w_write_en && (r_wr_ptr == PTR_W'(gi))) begin
          r_mem_instr[gi] <= Instruction;
          r_mem_pc[gi]    <= PCResult;
        end
      end
    end
  endgenerate

  // Discards = buffered words not consumed this cycle plus any word fetch offered.
  assign w_discard_sum = 16'(r_discard) + 16'(r_count) - 16'(w_pop) + 16'(InValid);

  always_comb begin
    w_wr_ptr_next  = r_wr_ptr;
    w_rd_ptr_next  = r_rd_ptr;
    w_count_next   = r_count;
    w_discard_next = r_discard;
    if (Flush) begin
      w_wr_ptr_next  = '0;
      w_rd_ptr_next  = '0;
      w_count_next   = '0;
      w_discard_next = (w_discard_sum > 16'd255) ? 8'd255 : w_discard_sum[7:0];
    end else begin
      if (w_push) begin
        w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
        2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_discard <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_count   <= w_count_next;
      r_discard <= w_discard_next;
    end
  end

  assign w_head_instr   = r_mem_instr[r_rd_ptr];
  assign w_head_pc      = r_mem_pc[r_rd_ptr];
  assign ID_Instruction = ID_Valid ? w_head_instr : 32'h0;
  assign ID_PC          = ID_Valid ? w_head_pc : 32'h0;
  assign ID_PCPlus4     = ID_Valid ? (w_head_pc + 32'd4) : 32'h0;
  assign Count          = r_count;
  assign DiscardCount   = r_discard;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=2).
module tb_if_id_buffer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instruction = '0;
  logic [31:0] PCResult = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        Flush = 1'b0;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic        ID_Ready = 1'b0;
  logic [1:0]  Count;
  logic [7:0]  DiscardCount;

  int pass_cnt = 0;
  int total_cnt = 0;

  if_id_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .PCResult(PCResult),
    .InValid(InValid), .InReady(InReady), .Flush(Flush),
    .ID_Instruction(ID_Instruction), .ID_PC(ID_PC), .ID_PCPlus4(ID_PCPlus4),
    .ID_Valid(ID_Valid), .ID_Ready(ID_Ready), .Count(Count), .DiscardCount(DiscardCount)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'hA000_0000 ^ pc;
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    total_cnt++; if (ID_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ID_Valid); else pass_cnt++;
    total_cnt++; if (Count !== 2'd0) $display("FAIL reset_count got %0d want 0", Count); else pass_cnt++;
    total_cnt++; if (InReady !== 1'b1) $display("FAIL reset_inready got %b want 1", InReady); else pass_cnt++;
    total_cnt++; if (ID_Instruction !== 32'h0) $display("FAIL reset_instr got %h want 0", ID_Instruction); else pass_cnt++;
    total_cnt++; if (DiscardCount !== 8'd0) $display("FAIL reset_discard got %0d want 0", DiscardCount); else pass_cnt++;
    total_cnt++; if (ID_PCPlus4 !== 32'h0) $display("FAIL reset_pcplus4 got %h want 0", ID_PCPlus4); else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_single();
    Instruction = 32'h2008_0005; PCResult = 32'h0; InValid = 1'b1; ID_Ready = 1'b1;
    step();
    InValid = 1'b0;
    $display("push pc=%h instr=%h", 32'h0, 32'h2008_0005);
    total_cnt++; if (ID_Valid !== 1'b1) $display("FAIL single_valid got %b want 1", ID_Valid); else pass_cnt++;
    total_cnt++; if (ID_Instruction !== 32'h2008_0005) $display("FAIL single_instr got %h want 20080005", ID_Instruction); else pass_cnt++;
    total_cnt++; if (ID_PCPlus4 !== 32'h4) $display("FAIL single_pcplus4 got %h want 4", ID_PCPlus4); else pass_cnt++;
    total_cnt++; if (Count !== 2'd1) $display("FAIL single_count1 got %0d want 1", Count); else pass_cnt++;
    step();
    $display("pop pc=%h", 32'h0);
    total_cnt++; if (Count !== 2'd0) $display("FAIL single_count0 got %0d want 0", Count); else pass_cnt++;
    total_cnt++; if (ID_Valid !== 1'b0) $display("FAIL single_empty got %b want 0", ID_Valid); else pass_cnt++;
    ID_Ready = 1'b0;
  endtask

  task automatic test_backpressure();
    ID_Ready = 1'b0; InValid = 1'b1;
    PCResult = 32'h0; Instruction = word_of(32'h0);
    step();
    total_cnt++; if (Count !== 2'd1) $display("FAIL bp_count1 got %0d want 1", Count); else pass_cnt++;
    PCResult = 32'h4; Instruction = word_of(32'h4);
    step();
    total_cnt++; if (Count !== 2'd2) $display("FAIL bp_count2 got %0d want 2", Count); else pass_cnt++;
    total_cnt++; if (InReady !== 1'b0) $display("FAIL bp_inready_full got %b want 0", InReady); else pass_cnt++;
    PCResult = 32'h8; Instruction = word_of(32'h8);
    step();
    $display("fetch holds pc=%h while full", 32'h8);
    total_cnt++; if (Count !== 2'd2) $display("FAIL bp_count_hold got %0d want 2", Count); else pass_cnt++;
    total_cnt++; if (ID_PC !== 32'h0) $display("FAIL bp_head_stable got %h want 0", ID_PC); else pass_cnt++;
    ID_Ready = 1'b1;
    total_cnt++; if (ID_Instruction !== word_of(32'h0)) $display("FAIL bp_out0 got %h want %h", ID_Instruction, word_of(32'h0)); else pass_cnt++;
    step();
    total_cnt++; if (ID_PC !== 32'h4) $display("FAIL bp_out4 got %h want 4", ID_PC); else pass_cnt++;
    total_cnt++; if (InReady !== 1'b1) $display("FAIL bp_inready_free got %b want 1", InReady); else pass_cnt++;
    step();
    total_cnt++; if (ID_PC !== 32'h8) $display("FAIL bp_out8 got %h want 8", ID_PC); else pass_cnt++;
    total_cnt++; if (ID_Instruction !== word_of(32'h8)) $display("FAIL bp_instr8 got %h want %h", ID_Instruction, word_of(32'h8)); else pass_cnt++;
    InValid = 1'b0;
    step();
    total_cnt++; if (Count !== 2'd0) $display("FAIL bp_drained got %0d want 0", Count); else pass_cnt++;
    ID_Ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    ID_Ready = 1'b0; InValid = 1'b1;
    PCResult = 32'h100; Instruction = word_of(32'h100);
    step();
    for (int i = 1; i <= 5; i++) begin
      pc = 32'h100 + 32'(i) * 32'd4;
      PCResult = pc; Instruction = word_of(pc); ID_Ready = 1'b1;
      step();
      $display("push pc=%h / pop pc=%h", pc, pc - 32'd4);
      total_cnt++; if (Count !== 2'd1) $display("FAIL b2b_count[%0d] got %0d want 1", i, Count); else pass_cnt++;
      total_cnt++; if (ID_PC !== pc) $display("FAIL b2b_head[%0d] got %h want %h", i, ID_PC, pc); else pass_cnt++;
    end
    InValid = 1'b0;
    step();
    ID_Ready = 1'b0;
    total_cnt++; if (Count !== 2'd0) $display("FAIL b2b_drained got %0d want 0", Count); else pass_cnt++;
  endtask

  task automatic test_flush();
    int exp_discard;
    exp_discard = 0;
    // flush with a pop in the same cycle: only the unconsumed word counts
    ID_Ready = 1'b0; InValid = 1'b1;
    PCResult = 32'h40; Instruction = word_of(32'h40); step();
    PCResult = 32'h44; Instruction = word_of(32'h44); step();
    InValid = 1'b0; ID_Ready = 1'b1; Flush = 1'b1;
    step();
    Flush = 1'b0; ID_Ready = 1'b0;
    exp_discard = 1;
    total_cnt++; if (DiscardCount !== 8'(exp_discard)) $display("FAIL flush_pop_discard got %0d want %0d", DiscardCount, exp_discard); else pass_cnt++;
    for (int n = 0; n < 90; n++) begin
      InValid = 1'b1;
      PCResult = 32'h200; Instruction = word_of(32'h200); step();
      PCResult = 32'h204; Instruction = word_of(32'h204); step();
      PCResult = 32'h208; Instruction = word_of(32'h208); Flush = 1'b1;
      if (n == 0) begin
        total_cnt++; if (InReady !== 1'b0) $display("FAIL flush_inready got %b want 0", InReady); else pass_cnt++;
      end
      step();
      Flush = 1'b0; InValid = 1'b0;
      exp_discard = (exp_discard + 3 > 255) ? 255 : exp_discard + 3;
      if (n == 0) begin
        total_cnt++; if (Count !== 2'd0) $display("FAIL flush_count got %0d want 0", Count); else pass_cnt++;
        total_cnt++; if (ID_Valid !== 1'b0) $display("FAIL flush_valid got %b want 0", ID_Valid); else pass_cnt++;
        total_cnt++; if (DiscardCount !== 8'd4) $display("FAIL flush_discard got %0d want 4", DiscardCount); else pass_cnt++;
      end
    end
    $display("90 flushes issued, discard=%0d", DiscardCount);
    total_cnt++; if (DiscardCount !== 8'd255) $display("FAIL flush_saturate got %0d want 255", DiscardCount); else pass_cnt++;
    total_cnt++; if (DiscardCount !== 8'(exp_discard)) $display("FAIL flush_model got %0d want %0d", DiscardCount, exp_discard); else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    ID_Ready = 1'b0; InValid = 1'b1;
    PCResult = 32'hFFFF_FFFC; Instruction = 32'h1234_5678;
    step();
    PCResult = 32'h0000_0010; Instruction = 32'h8765_4321;
    total_cnt++; if (ID_PC !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", ID_PC); else pass_cnt++;
    total_cnt++; if (ID_PCPlus4 !== 32'h0) $display("FAIL wrap_pcplus4 got %h want 0", ID_PCPlus4); else pass_cnt++;
    step();
    InValid = 1'b0;
    total_cnt++; if (Count !== 2'd2) $display("FAIL wrap_count2 got %0d want 2", Count); else pass_cnt++;
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    $display("mid-operation reset");
    total_cnt++; if (Count !== 2'd0) $display("FAIL midreset_count got %0d want 0", Count); else pass_cnt++;
    total_cnt++; if (ID_Valid !== 1'b0) $display("FAIL midreset_valid got %b want 0", ID_Valid); else pass_cnt++;
    total_cnt++; if (DiscardCount !== 8'd0) $display("FAIL midreset_discard got %0d want 0", DiscardCount); else pass_cnt++;
    total_cnt++; if (InReady !== 1'b1) $display("FAIL midreset_inready got %b want 1", InReady); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
